s_adc_spi_reader: RTL and testbench
===================================

// Module: s_adc_spi_reader
// PURPOSE
//  Serial front end for a 24-bit SPI ADC. Frames conversions, clocks the
//  result out MSB-first and presents it as a signed 24-bit sample held
//  between frames. Sits directly upstream of the subsampling accumulator,
//  which consumes Sample on every Clk.
// PARAMETERS
//  CLK_DIV       4   Clk cycles per SClk half-period; legal range 3..255
//  CONV_CYCLES   64  Clk cycles nCS is held high per conversion; legal range 1..65535
//  OFFSET_BINARY 0   1: ADC outputs offset binary, so the received MSB is inverted
// PORTS
//  nReset     in   1   asynchronous, active-low reset
//  Clk        in   1   system clock; all logic on posedge Clk
//  Enable     in   1   level; 1 = run conversions back to back
//  ADC_SDO    in   1   serial data from ADC, asynchronous to Clk
//  ADC_nCS    out  1   ADC chip select / convert-start, active low
//  ADC_SClk   out  1   serial clock; idles low
//  Sample     out  24  last complete sample, two's complement, held
//  Valid      out  1   one-Clk pulse when Sample updates
//  Busy       out  1   1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async) applies: state=IDLE, ADC_nCS=1, ADC_SClk=0, Sample=0,
//   Valid=0, Busy=0, shift reg=0, counters=0, synchroniser flops=0.
//  ADC_SDO passes through a 2-flop synchroniser before any use.
//  All outputs are registered.
//  States:
//   IDLE     nCS=1, SClk=0. Goes to CONVERT on the first Clk with Enable=1.
//   CONVERT  nCS=1 for exactly CONV_CYCLES Clks, then goes to SELECT.
//   SELECT   nCS=0, SClk=0 for CLK_DIV Clks (ADC setup), then goes to SHIFT.
//   SHIFT    24 bits; each bit is CLK_DIV Clks SClk=0, then CLK_DIV Clks SClk=1.
//            On the last Clk of each high half, shift the synchronised SDO
//            into the LSB of the shift register (MSB is received first).
//            After bit 24's high half, SClk returns to 0 and the state
//            goes to DONE.
//   DONE     one Clk: nCS=1; Sample <= shift reg (MSB inverted if
//            OFFSET_BINARY); Valid=1 on this Clk only. Next state is
//            CONVERT if Enable=1, otherwise IDLE.
//  Frame length = CONV_CYCLES + 49*CLK_DIV + 1 Clks (261 with defaults).
//  Sample changes only in DONE and is otherwise held constant, so the
//   downstream accumulator integrates a zero-order-held waveform.
//  Enable dropped mid-frame: the current frame completes and the block
//   then returns to IDLE. There is no partial-frame abort.
//  Enable re-raised in DONE: the next frame starts without passing
//   through IDLE.
//  Reset mid-frame: the block immediately forces the reset state. The
//   partial word is discarded and Valid does not pulse.
//  SDO is ignored outside SHIFT. SClk toggles only in SHIFT.
//  nCS is low only in SELECT and SHIFT.
//  Counter widths are derived from the parameters with $clog2.
//   No counter may wrap within a state.
// TESTING
//  1 Reset: hold nReset=0, toggle SDO -> nCS=1, SClk=0, Sample=0,
//    Valid=0, Busy=0 throughout.
//  2 Single frame, defaults: ADC model sends 24'h800001, Enable pulsed
//    for 1 Clk -> exactly 24 SClk rising edges; Sample=24'h800001;
//    Valid high for exactly 1 Clk, 261 Clks after Enable is sampled;
//    then IDLE.
//  3 OFFSET_BINARY=1: model sends 24'h800000 -> Sample=24'h000000.
//    Model sends 24'hFFFFFF -> Sample=24'h7FFFFF.
//  4 Continuous: Enable=1, model sends 1,2,3 -> Valid pulses exactly
//    261 Clks apart; Sample steps 1,2,3 and is stable between pulses.
//  5 Enable dropped at SClk edge 10 of a frame -> frame completes,
//    Valid pulses once, block returns to IDLE with no further nCS low.
//  6 nReset asserted at bit 12 -> nCS=1 and SClk=0 immediately;
//    Sample keeps its reset value 0; no Valid pulse.
//    Next frame after release reads correctly.

Source files
------------

// File: rtl/s_adc_spi_reader.sv
// Serial front end for a 24-bit SPI ADC: frames a conversion, clocks the word in
// MSB-first and holds it as a two's-complement sample between frames.
module s_adc_spi_reader #(
  parameter int CLK_DIV       = 4,
  parameter int CONV_CYCLES   = 64,
  parameter bit OFFSET_BINARY = 1'b0
) (
  input  logic        nReset,
  input  logic        Clk,
  input  logic        Enable,
  input  logic        ADC_SDO,
  output logic        ADC_nCS,
  output logic        ADC_SClk,
  output logic [23:0] Sample,
  output logic        Valid,
  output logic        Busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CONVERT = 3'd1;
  localparam logic [2:0] ST_SELECT  = 3'd2;
  localparam logic [2:0] ST_SHIFT   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);
  localparam logic [23:0]   MSB_FLIP  = {OFFSET_BINARY, 23'd0};

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] conv_cnt_q, conv_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic          sclk_q, sclk_d;
  logic          ncs_q;
  logic          busy_q;
  logic          valid_q;
  logic [23:0]   sample_q;
  logic          sdo_meta_q, sdo_sync_q;

  always_comb begin
    state_d    = state_q;
    conv_cnt_d = conv_cnt_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sclk_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Enable) begin
          state_d    = ST_CONVERT;
          conv_cnt_d = '0;
        end
      end
      ST_CONVERT: begin
        if (conv_cnt_q == CONV_LAST) begin
          state_d   = ST_SELECT;
          div_cnt_d = '0;
        end else begin
          conv_cnt_d = conv_cnt_q + 1'b1;
        end
      end
      ST_SELECT: begin
        if (div_cnt_q == DIV_LAST) begin
          state_d   = ST_SHIFT;
          div_cnt_d = '0;
          bit_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        sclk_d = sclk_q;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Sample at the end of the high half, just before SClk falls
            sclk_d  = 1'b0;
            shift_d = {shift_q[22:0], sdo_sync_q};
            if (bit_cnt_q == 5'd23) begin
              state_d = ST_DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d    = Enable ? ST_CONVERT : ST_IDLE;
        conv_cnt_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= ST_IDLE;
      conv_cnt_q <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sclk_q     <= 1'b0;
      ncs_q      <= 1'b1;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      sample_q   <= '0;
      sdo_meta_q <= 1'b0;
      sdo_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_cnt_q <= conv_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sclk_q     <= sclk_d;
      ncs_q      <= !((state_d == ST_SELECT) || (state_d == ST_SHIFT));
      busy_q     <= (state_d != ST_IDLE);
      valid_q    <= (state_d == ST_DONE);
      if (state_d == ST_DONE) begin
        sample_q <= shift_d ^ MSB_FLIP;
      end
      sdo_meta_q <= ADC_SDO;
      sdo_sync_q <= sdo_meta_q;
    end
  end

  assign ADC_nCS  = ncs_q;
  assign ADC_SClk = sclk_q;
  assign Sample   = sample_q;
  assign Valid    = valid_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_s_adc_spi_reader.sv
// Bench for s_adc_spi_reader: behavioural ADC models feed two instances (straight
// and offset-binary); a scoreboard of expected samples is checked on every Valid.
module tb_s_adc_spi_reader;

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic        en0 = 1'b0, en1 = 1'b0;
  logic        sdo_model0 = 1'b0, sdo_model1 = 1'b0, sdo_noise = 1'b0;
  logic        sdo0, sdo1;
  logic        ncs0, sclk0, valid0, busy0;
  logic        ncs1, sclk1, valid1, busy1;
  logic [23:0] sample0, sample1;

  assign sdo0 = sdo_model0 ^ sdo_noise;
  assign sdo1 = sdo_model1 ^ sdo_noise;

  always #5 Clk = ~Clk;

  s_adc_spi_reader dut (
    .nReset(nReset), .Clk(Clk), .Enable(en0), .ADC_SDO(sdo0),
    .ADC_nCS(ncs0), .ADC_SClk(sclk0), .Sample(sample0), .Valid(valid0), .Busy(busy0)
  );

  s_adc_spi_reader #(.OFFSET_BINARY(1'b1)) dut_ob (
    .nReset(nReset), .Clk(Clk), .Enable(en1), .ADC_SDO(sdo1),
    .ADC_nCS(ncs1), .ADC_SClk(sclk1), .Sample(sample1), .Valid(valid1), .Busy(busy1)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // ADC models: MSB presented at nCS fall, next bit after each SClk fall
  logic [23:0] words0[$], words1[$];
  logic [23:0] cur0 = '0, cur1 = '0;
  int idx0 = 0, idx1 = 0;
  int ncs_fall0 = 0, rise0 = 0;

  always @(negedge ncs0) begin
    ncs_fall0++;
    if (words0.size() > 0) cur0 = words0.pop_front();
    else cur0 = '0;
    idx0 = 23;
    sdo_model0 = cur0[23];
  end
  always @(negedge sclk0) begin
    if (idx0 > 0) idx0--;
    sdo_model0 = cur0[idx0];
  end
  always @(posedge sclk0) rise0++;

  always @(negedge ncs1) begin
    if (words1.size() > 0) cur1 = words1.pop_front();
    else cur1 = '0;
    idx1 = 23;
    sdo_model1 = cur1[23];
  end
  always @(negedge sclk1) begin
    if (idx1 > 0) idx1--;
    sdo_model1 = cur1[idx1];
  end

  // Scoreboard and output monitor
  logic [23:0] exp0[$], exp1[$];
  int vcount0 = 0, vcount1 = 0;
  int vcyc0[$];
  logic pv0 = 1'b0, pv1 = 1'b0;
  logic [23:0] held0 = '0;
  int stable_err0 = 0;

  always @(negedge Clk) begin
    if (valid0) begin
      vcount0++;
      vcyc0.push_back(cyc);
      $display("dut    sample %06h at cycle %0d", sample0, cyc);
      check("valid0_width", {31'd0, pv0}, 0);
      check("sb0_nonempty", {31'd0, exp0.size() != 0}, 1);
      if (exp0.size() != 0) check("sample0", {8'd0, sample0}, {8'd0, exp0.pop_front()});
      held0 = sample0;
    end else if (!nReset) begin
      held0 = '0;
    end else if (sample0 !== held0) begin
      stable_err0++;
    end
    if (valid1) begin
      vcount1++;
      $display("dut_ob sample %06h at cycle %0d", sample1, cyc);
      check("valid1_width", {31'd0, pv1}, 0);
      check("sb1_nonempty", {31'd0, exp1.size() != 0}, 1);
      if (exp1.size() != 0) check("sample1", {8'd0, sample1}, {8'd0, exp1.pop_front()});
    end
    pv0 = valid0;
    pv1 = valid1;
  end

  task automatic wait_v0(input int target, input int budget);
    for (int i = 0; i < budget && vcount0 < target; i++) @(negedge Clk);
    check("wait_valid0", {31'd0, vcount0 >= target}, 1);
  endtask

  task automatic wait_v1(input int target, input int budget);
    for (int i = 0; i < budget && vcount1 < target; i++) @(negedge Clk);
    check("wait_valid1", {31'd0, vcount1 >= target}, 1);
  endtask

  task automatic wait_rise0(input int target, input int budget);
    for (int i = 0; i < budget && rise0 < target; i++) @(negedge Clk);
    check("wait_sclk0", {31'd0, rise0 >= target}, 1);
  endtask

  task automatic frame0(input logic [23:0] word);
    int bv, br, t0;
    words0.push_back(word);
    exp0.push_back(word);
    bv = vcount0;
    br = rise0;
    @(negedge Clk);
    en0 = 1'b1;
    t0 = cyc;
    @(negedge Clk);
    en0 = 1'b0;
    wait_v0(bv + 1, 400);
    // Latency counts the edge that samples Enable as cycle 1
    check("latency", vcyc0[vcyc0.size()-1] - t0, 261);
    check("sclk_rises", rise0 - br, 24);
    repeat (5) @(negedge Clk);
    check("idle_busy", {31'd0, busy0}, 0);
    check("idle_ncs", {31'd0, ncs0}, 1);
    check("one_valid", vcount0 - bv, 1);
  endtask

  initial begin
    int bv, br, bf, n;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv, br, bf, n;
    // Reset held with Enable high and SDO toggling
    en0 = 1'b1;
    en1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      sdo_noise = ~sdo_noise;
      check("rst_ncs", {31'd0, ncs0}, 1);
      check("rst_sclk", {31'd0, sclk0}, 0);
      check("rst_sample", {8'd0, sample0}, 0);
      check("rst_valid", {31'd0, valid0}, 0);
      check("rst_busy", {31'd0, busy0}, 0);
    end
    en0 = 1'b0;
    en1 = 1'b0;
    sdo_noise = 1'b0;
    @(negedge Clk);
    nReset = 1'b1;
    repeat (3) @(negedge Clk);

    // Single frame, defaults
    frame0(24'h800001);

    // Offset-binary instance
    words1.push_back(24'h800000); exp1.push_back(24'h000000);
    words1.push_back(24'hFFFFFF); exp1.push_back(24'h7FFFFF);
    for (int k = 0; k < 2; k++) begin
      bv = vcount1;
      @(negedge Clk); en1 = 1'b1;
      @(negedge Clk); en1 = 1'b0;
      wait_v1(bv + 1, 400);
      repeat (3) @(negedge Clk);
      check("ob_idle", {31'd0, busy1}, 0);
    end

    // Continuous conversions
    for (int k = 1; k <= 3; k++) begin
      words0.push_back(24'(k));
      exp0.push_back(24'(k));
    end
    bv = vcount0;
    bf = stable_err0;
    @(negedge Clk); en0 = 1'b1;
    wait_v0(bv + 2, 700);
    repeat (5) @(negedge Clk);
    en0 = 1'b0;
    wait_v0(bv + 3, 400);
    n = vcyc0.size();
    check("spacing_1_2", vcyc0[n-2] - vcyc0[n-3], 261);
    check("spacing_2_3", vcyc0[n-1] - vcyc0[n-2], 261);
    check("sample_held", stable_err0 - bf, 0);
    repeat (300) @(negedge Clk);
    check("cont_count", vcount0 - bv, 3);
    check("cont_idle", {31'd0, busy0}, 0);

    // Enable dropped at the tenth SClk rise
    words0.push_back(24'hA5A5A5);
    exp0.push_back(24'hA5A5A5);
    bv = vcount0;
    br = rise0;
    @(negedge Clk); en0 = 1'b1;
    wait_rise0(br + 10, 400);
    en0 = 1'b0;
    wait_v0(bv + 1, 400);
    check("drop_rises", rise0 - br, 24);
    bf = ncs_fall0;
    repeat (300) @(negedge Clk);
    check("drop_no_ncs", ncs_fall0 - bf, 0);
    check("drop_count", vcount0 - bv, 1);
    check("drop_idle", {31'd0, busy0}, 0);

    // Reset during bit 12; that word is discarded
    words0.push_back(24'h5A5A5A);
    bv = vcount0;
    br = rise0;
    @(negedge Clk); en0 = 1'b1;
    @(negedge Clk); en0 = 1'b0;
    wait_rise0(br + 12, 400);
    nReset = 1'b0;
    #1;
    check("abort_ncs", {31'd0, ncs0}, 1);
    check("abort_sclk", {31'd0, sclk0}, 0);
    check("abort_sample", {8'd0, sample0}, 0);
    check("abort_busy", {31'd0, busy0}, 0);
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    repeat (300) @(negedge Clk);
    check("abort_no_valid", vcount0 - bv, 0);
    check("abort_sample_kept", {8'd0, sample0}, 0);
    frame0(24'h3C0FF1);

    check("sb0_drained", exp0.size(), 0);
    check("sb1_drained", exp1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
